// File: rtl/qpu_exu_tevq_issue_pkg.sv
// Shared widths, depth and state encodings for the EXU time/event issue queue.
// Values mirror the QPU global defines so the queue matches the rest of the QPU.
package qpu_exu_tevq_issue_pkg;

  localparam int QPU_TIME_WIDTH       = 32;
  localparam int QPU_EVENT_WIRE_WIDTH = 64;
  localparam int QPU_EVENT_NUM        = 8;
  localparam int QPU_TEVQ_DEPTH       = 8;

  localparam logic [0:0] QPU_TEVQ_IDLE = 1'b0;
  localparam logic [0:0] QPU_TEVQ_RUN  = 1'b1;

  // Pointer width carries one extra wrap bit to tell full from empty.
  function automatic int tevq_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/qpu_sync_fifo.sv
// Generic single-clock FIFO with show-ahead head and wrap-bit pointers.
module qpu_sync_fifo
  import qpu_exu_tevq_issue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = tevq_ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/qpu_exu_tevq_issue.sv
// Time/event queue consumer: buffers write-back entries, runs the QPU timeline and
// issues each event once the timeline reaches the entry's time point.
module qpu_exu_tevq_issue
  import qpu_exu_tevq_issue_pkg::*;
#(
  parameter int TIME_W    = QPU_TIME_WIDTH,
  parameter int EVENT_W   = QPU_EVENT_WIRE_WIDTH,
  parameter int EVENT_NUM = QPU_EVENT_NUM,
  parameter int DEPTH     = QPU_TEVQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tiq_wbck_i_ena,
  output logic                 tiq_wbck_i_ready,
  input  logic [TIME_W-1:0]    tiq_wbck_i_data,
  input  logic                 evq_wbck_i_ena,
  output logic                 evq_wbck_i_ready,
  input  logic [EVENT_W-1:0]   evq_wbck_i_data,
  input  logic [EVENT_NUM-1:0] evq_wbck_i_oprand,
  input  logic                 start_i,
  input  logic                 flush_i,
  output logic                 event_o_valid,
  output logic [EVENT_W-1:0]   event_o_data,
  output logic [EVENT_NUM-1:0] event_o_oprand,
  output logic [TIME_W-1:0]    timer_o,
  output logic                 busy_o,
  output logic                 late_o,
  output logic                 pair_err_o,
  output logic                 timer_ovf_o
);

  localparam int ENTRY_W = TIME_W + EVENT_W + EVENT_NUM;

  logic [ENTRY_W-1:0]   head;
  logic [TIME_W-1:0]    head_time;
  logic [EVENT_W-1:0]   head_data;
  logic [EVENT_NUM-1:0] head_oprand;
  logic                 full, empty, push, pop;

  logic [0:0]           state_q, state_d;
  logic [TIME_W-1:0]    timer_q, timer_d;
  logic                 valid_q;
  logic [EVENT_W-1:0]   data_q;
  logic [EVENT_NUM-1:0] oprand_q;
  logic                 late_q, late_d;
  logic                 pair_q, pair_d;
  logic                 ovf_q, ovf_d;

  qpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_i),
    .push_i  (push),
    .din_i   ({tiq_wbck_i_data, evq_wbck_i_data, evq_wbck_i_oprand}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {head_time, head_data, head_oprand} = head;

  assign push = tiq_wbck_i_ena & evq_wbck_i_ena & ~full & ~flush_i;
  // Late entries pop as soon as they reach the head, so <= covers on-time and late.
  assign pop  = (state_q == QPU_TEVQ_RUN) & ~empty & (head_time <= timer_q) & ~flush_i;

  assign tiq_wbck_i_ready = ~full;
  assign evq_wbck_i_ready = ~full;
  assign busy_o           = (state_q == QPU_TEVQ_RUN) | ~empty;
  assign timer_o          = timer_q;
  assign event_o_valid    = valid_q;
  assign event_o_data     = data_q;
  assign event_o_oprand   = oprand_q;
  assign late_o           = late_q;
  assign pair_err_o       = pair_q;
  assign timer_ovf_o      = ovf_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ovf_d   = ovf_q;
    late_d  = late_q | (pop & (head_time < timer_q));
    pair_d  = pair_q | (tiq_wbck_i_ena ^ evq_wbck_i_ena);
    if (flush_i) begin
      state_d = QPU_TEVQ_IDLE;
      timer_d = '0;
      ovf_d   = 1'b0;
      late_d  = 1'b0;
      pair_d  = 1'b0;
    end else if (start_i) begin
      state_d = QPU_TEVQ_RUN;
      timer_d = '0;
    end else if (state_q == QPU_TEVQ_RUN) begin
      if (timer_q == {TIME_W{1'b1}}) ovf_d = 1'b1;
      else                           timer_d = timer_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= QPU_TEVQ_IDLE;
      timer_q  <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      oprand_q <= '0;
      late_q   <= 1'b0;
      pair_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= pop;
      late_q  <= late_d;
      pair_q  <= pair_d;
      ovf_q   <= ovf_d;
      if (pop) begin
        data_q   <= head_data;
        oprand_q <= head_oprand;
      end
    end
  end

endmodule

// File: tb/tb_qpu_exu_tevq_issue.sv
// Directed bench for the time/event issue queue; a second instance with a 4-bit
// timeline exercises saturation.
module tb_qpu_exu_tevq_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tiq_ena, evq_ena, start, flush;
  logic [31:0] tiq_data;
  logic [63:0] evq_data;
  logic [7:0]  evq_op;
  logic        tiq_ready, evq_ready, ev_valid, busy, late, pair_err, ovf;
  logic [63:0] ev_data;
  logic [7:0]  ev_op;
  logic [31:0] timer;

  logic        start2, flush2, zero_ena;
  logic [3:0]  tiq_data2;
  logic        tiq_ready2, evq_ready2, ev_valid2, busy2, late2, pair_err2, ovf2;
  logic [63:0] ev_data2;
  logic [7:0]  ev_op2;
  logic [3:0]  timer2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  qpu_exu_tevq_issue dut (
    .clk(clk), .rst_n(rst_n),
    .tiq_wbck_i_ena(tiq_ena), .tiq_wbck_i_ready(tiq_ready), .tiq_wbck_i_data(tiq_data),
    .evq_wbck_i_ena(evq_ena), .evq_wbck_i_ready(evq_ready), .evq_wbck_i_data(evq_data),
    .evq_wbck_i_oprand(evq_op), .start_i(start), .flush_i(flush),
    .event_o_valid(ev_valid), .event_o_data(ev_data), .event_o_oprand(ev_op),
    .timer_o(timer), .busy_o(busy), .late_o(late), .pair_err_o(pair_err), .timer_ovf_o(ovf)
  );

  qpu_exu_tevq_issue #(.TIME_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .tiq_wbck_i_ena(zero_ena), .tiq_wbck_i_ready(tiq_ready2), .tiq_wbck_i_data(tiq_data2),
    .evq_wbck_i_ena(zero_ena), .evq_wbck_i_ready(evq_ready2), .evq_wbck_i_data(evq_data),
    .evq_wbck_i_oprand(evq_op), .start_i(start2), .flush_i(flush2),
    .event_o_valid(ev_valid2), .event_o_data(ev_data2), .event_o_oprand(ev_op2),
    .timer_o(timer2), .busy_o(busy2), .late_o(late2), .pair_err_o(pair_err2), .timer_ovf_o(ovf2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] t, input logic [63:0] ev, input logic [7:0] op);
    tiq_ena = 1'b1; evq_ena = 1'b1; tiq_data = t; evq_data = ev; evq_op = op;
    tick();
    tiq_ena = 1'b0; evq_ena = 1'b0;
    $display("push t=%0d ev=0x%0h op=0x%0h", t, ev, op);
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_timer(input logic [31:0] v, input int budget);
    int n = 0;
    while (timer !== v && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (timer !== v) $display("FAIL wait_timer: timer=%0d required=%0d", timer, v);
    else passed++;
  endtask

  task automatic test_reset;
    checks++; if (tiq_ready !== 1'b1 || evq_ready !== 1'b1) $display("FAIL rst_ready: %b%b required 11", tiq_ready, evq_ready); else passed++;
    checks++; if (ev_valid !== 1'b0 || ev_data !== 64'd0 || ev_op !== 8'd0) $display("FAIL rst_event: v=%b d=%0h o=%0h required 0", ev_valid, ev_data, ev_op); else passed++;
    checks++; if (timer !== 32'd0 || busy !== 1'b0) $display("FAIL rst_timer_busy: t=%0d b=%b required 0", timer, busy); else passed++;
    checks++; if ({late, pair_err, ovf} !== 3'b000) $display("FAIL rst_flags: %b required 000", {late, pair_err, ovf}); else passed++;
    $display("reset checked");
  endtask

  task automatic test_single_issue;
    tiq_ena = 1'b1; evq_ena = 1'b1; tiq_data = 32'd5; evq_data = 64'hA; evq_op = 8'h01; start = 1'b1;
    tick();
    tiq_ena = 1'b0; evq_ena = 1'b0; start = 1'b0;
    checks++; if (timer !== 32'd0 || busy !== 1'b1) $display("FAIL t1_start: t=%0d b=%b required 0,1", timer, busy); else passed++;
    wait_timer(32'd5, 20);
    checks++; if (ev_valid !== 1'b0) $display("FAIL t1_early: valid=%b required 0", ev_valid); else passed++;
    tick();
    $display("issue v=%b d=0x%0h o=0x%0h late=%b", ev_valid, ev_data, ev_op, late);
    checks++; if (ev_valid !== 1'b1 || ev_data !== 64'hA || ev_op !== 8'h01) $display("FAIL t1_issue: v=%b d=%0h o=%0h required 1,a,1", ev_valid, ev_data, ev_op); else passed++;
    checks++; if (late !== 1'b0) $display("FAIL t1_late: %b required 0", late); else passed++;
    tick();
    checks++; if (ev_valid !== 1'b0 || ev_data !== 64'hA) $display("FAIL t1_hold: v=%b d=%0h required 0,a", ev_valid, ev_data); else passed++;
  endtask

  task automatic test_duplicate_time;
    do_flush();
    push_entry(32'd3, 64'h11, 8'h02);
    push_entry(32'd7, 64'h12, 8'h04);
    push_entry(32'd7, 64'h13, 8'h08);
    start = 1'b1; tick(); start = 1'b0;
    wait_timer(32'd3, 20);
    tick();
    checks++; if (ev_valid !== 1'b1 || ev_data !== 64'h11 || ev_op !== 8'h02) $display("FAIL t2_first: v=%b d=%0h o=%0h required 1,11,2", ev_valid, ev_data, ev_op); else passed++;
    wait_timer(32'd7, 20);
    tick();
    checks++; if (ev_valid !== 1'b1 || ev_data !== 64'h12 || late !== 1'b0) $display("FAIL t2_second: v=%b d=%0h late=%b required 1,12,0", ev_valid, ev_data, late); else passed++;
    tick();
    $display("issue v=%b d=0x%0h o=0x%0h late=%b", ev_valid, ev_data, ev_op, late);
    checks++; if (ev_valid !== 1'b1 || ev_data !== 64'h13 || late !== 1'b1) $display("FAIL t2_third: v=%b d=%0h late=%b required 1,13,1", ev_valid, ev_data, late); else passed++;
  endtask

  task automatic test_full_queue;
    do_flush();
    for (int i = 0; i < 8; i++) push_entry(32'd100, 64'h100 + 64'(i), 8'(i));
    checks++; if (tiq_ready !== 1'b0 || evq_ready !== 1'b0) $display("FAIL t3_full: %b%b required 00", tiq_ready, evq_ready); else passed++;
    push_entry(32'd100, 64'hDEAD, 8'hFF);
    start = 1'b1; tick(); start = 1'b0;
    wait_timer(32'd100, 150);
    checks++; if (tiq_ready !== 1'b0 || ev_valid !== 1'b0) $display("FAIL t3_wait: rdy=%b v=%b required 0,0", tiq_ready, ev_valid); else passed++;
    for (int k = 0; k < 8; k++) begin
      tick();
      $display("issue v=%b d=0x%0h o=0x%0h", ev_valid, ev_data, ev_op);
      checks++; if (ev_valid !== 1'b1 || ev_data !== 64'h100 + 64'(k)) $display("FAIL t3_issue%0d: v=%b d=%0h required 1,%0h", k, ev_valid, ev_data, 64'h100 + 64'(k)); else passed++;
      if (k == 0) begin
        checks++; if (tiq_ready !== 1'b1 || evq_ready !== 1'b1) $display("FAIL t3_ready: %b%b required 11", tiq_ready, evq_ready); else passed++;
      end
    end
    tick();
    checks++; if (ev_valid !== 1'b0 || busy !== 1'b1) $display("FAIL t3_drop9: v=%b busy=%b required 0,1", ev_valid, busy); else passed++;
  endtask

  task automatic test_flush;
    do_flush();
    tiq_ena = 1'b1; evq_ena = 1'b0; tick(); tiq_ena = 1'b0;
    push_entry(32'd50, 64'h21, 8'h01);
    push_entry(32'd51, 64'h22, 8'h01);
    push_entry(32'd52, 64'h23, 8'h01);
    start = 1'b1; tick(); start = 1'b0;
    wait_timer(32'd2, 10);
    flush = 1'b1; tiq_ena = 1'b1; evq_ena = 1'b1; tiq_data = 32'd3; evq_data = 64'h99;
    tick();
    flush = 1'b0; tiq_ena = 1'b0; evq_ena = 1'b0;
    $display("flush at timer 2 with push");
    checks++; if (timer !== 32'd0 || busy !== 1'b0 || ev_valid !== 1'b0) $display("FAIL t4_cleared: t=%0d b=%b v=%b required 0,0,0", timer, busy, ev_valid); else passed++;
    checks++; if ({late, pair_err, ovf} !== 3'b000) $display("FAIL t4_flags: %b required 000", {late, pair_err, ovf}); else passed++;
    tick(); tick();
    checks++; if (timer !== 32'd0 || busy !== 1'b0) $display("FAIL t4_idle: t=%0d b=%b required 0,0", timer, busy); else passed++;
    start = 1'b1; tick(); start = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 60; i++) begin
        if (ev_valid === 1'b1) seen++;
        tick();
      end
      checks++; if (seen != 0) $display("FAIL t4_noissue: issues=%0d required 0", seen); else passed++;
    end
  endtask

  task automatic test_pair_and_saturate;
    do_flush();
    tiq_ena = 1'b1; evq_ena = 1'b0; tiq_data = 32'd9; tick(); tiq_ena = 1'b0;
    checks++; if (pair_err !== 1'b1 || busy !== 1'b0) $display("FAIL t5_pair: err=%b busy=%b required 1,0", pair_err, busy); else passed++;
    checks++; if (ovf2 !== 1'b0 || timer2 !== 4'd0) $display("FAIL t5_pre: ovf=%b t=%0d required 0,0", ovf2, timer2); else passed++;
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (20) tick();
    $display("saturation timer2=%0d ovf2=%b", timer2, ovf2);
    checks++; if (timer2 !== 4'd15 || ovf2 !== 1'b1 || busy2 !== 1'b1) $display("FAIL t5_sat: t=%0d ovf=%b busy=%b required 15,1,1", timer2, ovf2, busy2); else passed++;
  endtask

  task automatic test_async_reset;
    do_flush();
    tiq_ena = 1'b0; evq_ena = 1'b1; tick(); evq_ena = 1'b0;
    for (int i = 0; i < 4; i++) push_entry(32'd200, 64'h40 + 64'(i), 8'h10);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1 || timer !== 32'd2 || pair_err !== 1'b1) $display("FAIL t6_pre: b=%b t=%0d err=%b required 1,2,1", busy, timer, pair_err); else passed++;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-run");
    checks++; if (busy !== 1'b0 || timer !== 32'd0 || tiq_ready !== 1'b1 || evq_ready !== 1'b1) $display("FAIL t6_rst: b=%b t=%0d rdy=%b%b required 0,0,11", busy, timer, tiq_ready, evq_ready); else passed++;
    checks++; if ({ev_valid, late, pair_err, ovf, ovf2} !== 5'b0 || ev_data !== 64'd0) $display("FAIL t6_flags: %b d=%0h required 0", {ev_valid, late, pair_err, ovf, ovf2}, ev_data); else passed++;
    #10 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    tiq_ena = 1'b0; evq_ena = 1'b0; start = 1'b0; flush = 1'b0;
    tiq_data = '0; evq_data = '0; evq_op = '0;
    start2 = 1'b0; flush2 = 1'b0; zero_ena = 1'b0; tiq_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    tick();
    test_single_issue();
    test_duplicate_time();
    test_full_queue();
    test_flush();
    test_pair_and_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
